// File: rtl/aes_inv_round.sv
// One AES-128 inverse round with inverse key expansion, two register stages.
// Define AES_INV_SINGLE_STAGE_EN to merge both stages into one (latency 1).
module aes_inv_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    input  logic [0:3]   curRnd,
    input  logic [0:127] curRK,
    input  logic [0:127] rndDataIn,
    output logic         outValid,
    output logic [0:3]   outRnd,
    output logic [0:127] prevRK,
    output logic [0:127] rndDataOut,
    output logic         rndErr
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RND_W   = 4;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8); 0 maps to 0 naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // InvShiftRows (row i rotated right by i) followed by InvSubBytes
    function automatic logic [0:STATE_W-1] inv_final(input logic [0:STATE_W-1] s);
        logic [0:STATE_W-1] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(4*c+r) +: 8] = inv_sbox(s[8*(4*((c+4-r)%4)+r) +: 8]);
            end
        end
        return o;
    endfunction

    logic [0:STATE_W-1] ark;
    logic [0:STATE_W-1] imc;
    logic [0:STATE_W-1] s1_d;
    logic [0:STATE_W-1] key_d;
    logic               err_d;

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        ark = rndDataIn ^ curRK;
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[32*c      +: 8];
            a1 = ark[32*c + 8  +: 8];
            a2 = ark[32*c + 16 +: 8];
            a3 = ark[32*c + 24 +: 8];
            imc[32*c      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            imc[32*c + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            imc[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            imc[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        s1_d  = (curRnd == 4'd10) ? ark : imc;
        err_d = (curRnd == 4'd0) || (curRnd > 4'd10);
    end

    // Inverse key step: recover rk[r-1] from rk[r]
    always_comb begin
        logic [WORD_W-1:0] w0, w1, w2, w3, w0n, w1n, w2n, w3n, rot, sw;
        w0  = curRK[0:31];
        w1  = curRK[32:63];
        w2  = curRK[64:95];
        w3  = curRK[96:127];
        w3n = w3 ^ w2;
        w2n = w2 ^ w1;
        w1n = w1 ^ w0;
        rot = {w3n[23:0], w3n[31:24]};
        sw  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        w0n = w0 ^ sw ^ {rcon(curRnd), 24'h000000};
        key_d = {w0n, w1n, w2n, w3n};
    end

`ifdef AES_INV_SINGLE_STAGE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid   <= 1'b0;
            outRnd     <= '0;
            prevRK     <= '0;
            rndDataOut <= '0;
            rndErr     <= 1'b0;
        end else begin
            outValid <= inValid;
            if (inValid) begin
                outRnd     <= curRnd;
                prevRK     <= key_d;
                rndDataOut <= inv_final(s1_d);
                rndErr     <= err_d;
            end
        end
    end
`else
    logic               v_q;
    logic [0:RND_W-1]   rnd_q;
    logic [0:STATE_W-1] s1_q;
    logic [0:STATE_W-1] key_q;
    logic               err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q        <= 1'b0;
            rnd_q      <= '0;
            s1_q       <= '0;
            key_q      <= '0;
            err_q      <= 1'b0;
            outValid   <= 1'b0;
            outRnd     <= '0;
            prevRK     <= '0;
            rndDataOut <= '0;
            rndErr     <= 1'b0;
        end else begin
            v_q      <= inValid;
            outValid <= v_q;
            if (inValid) begin
                rnd_q <= curRnd;
                s1_q  <= s1_d;
                key_q <= key_d;
                err_q <= err_d;
            end
            if (v_q) begin
                outRnd     <= rnd_q;
                prevRK     <= key_q;
                rndDataOut <= inv_final(s1_q);
                rndErr     <= err_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_inv_round.sv
// Directed bench for aes_inv_round with known-answer AES-128 vectors.
module tb_aes_inv_round;

`ifdef AES_INV_SINGLE_STAGE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [0:3]   curRnd;
    logic [0:127] curRK;
    logic [0:127] rndDataIn;
    logic         outValid;
    logic [0:3]   outRnd;
    logic [0:127] prevRK;
    logic [0:127] rndDataOut;
    logic         rndErr;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] K1 = 128'hE232FCF191129188B159E4E6D679A293;
    localparam logic [127:0] D1 = 128'h5847088B15B61CBA59D4E2E8CD39DFCE;
    localparam logic [127:0] P1 = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] O1 = 128'h001F0E543C4E08596E221B0B4774311A;
    localparam logic [127:0] K2 = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
    localparam logic [127:0] D2 = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] P2 = 128'hAC7766F319FADC2128D12941575C006E;
    localparam logic [127:0] O2 = 128'hEB40F21E592E38848BA113E71BC342D2;

    aes_inv_round dut (
        .clk        (clk),
        .rst        (rst),
        .inValid    (inValid),
        .curRnd     (curRnd),
        .curRK      (curRK),
        .rndDataIn  (rndDataIn),
        .outValid   (outValid),
        .outRnd     (outRnd),
        .prevRK     (prevRK),
        .rndDataOut (rndDataOut),
        .rndErr     (rndErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [127:0] k,
                         input logic [127:0] d);
        inValid   = v;
        curRnd    = r;
        curRK     = k;
        rndDataIn = d;
    endtask

    // One-shot input, then wait (bounded) for the result strobe
    task automatic send_wait(input string tag, input logic [3:0] r, input logic [127:0] k,
                             input logic [127:0] d);
        int cyc;
        drive(1'b1, r, k, d);
        tick();
        inValid = 1'b0;
        cyc = 1;
        while (!outValid && cyc < 10) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 128'(cyc), 128'(LAT));
        chk({tag, "_vld"}, 128'(outValid), 128'(1));
    endtask

    task automatic chk_out(input string tag, input logic [3:0] r, input logic [127:0] key,
                           input logic [127:0] data, input logic err);
        chk({tag, "_rnd"},  128'(outRnd), 128'(r));
        chk({tag, "_key"},  prevRK, key);
        chk({tag, "_data"}, rndDataOut, data);
        chk({tag, "_err"},  128'(rndErr), 128'(err));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, 128'(outValid), 128'(0));
        chk_out(tag, 4'd0, 128'h0, 128'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'd1, K1, D1);
        tick();
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        drive(1'b0, 4'd0, 128'h0, 128'h0);
        tick();

        send_wait("rnd1", 4'd1, K1, D1);
        chk_out("rnd1", 4'd1, P1, O1, 1'b0);

        send_wait("rnd10", 4'd10, K2, D2);
        chk_out("rnd10", 4'd10, P2, O2, 1'b0);
        tick();
        chk("rnd10_bubble", 128'(outValid), 128'(0));

        // Back-to-back pair followed by a bubble
        drive(1'b1, 4'd1, K1, D1);
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            if (k == LAT) begin
                chk("b2b_v1_vld", 128'(outValid), 128'(1));
                chk_out("b2b_v1", 4'd1, P1, O1, 1'b0);
            end
            if (k == LAT + 1) begin
                chk("b2b_v2_vld", 128'(outValid), 128'(1));
                chk_out("b2b_v2", 4'd10, P2, O2, 1'b0);
            end
            if (k >= LAT + 2) begin
                chk("b2b_idle_vld", 128'(outValid), 128'(0));
                chk_out("b2b_hold", 4'd10, P2, O2, 1'b0);
            end
            if (k == 1) drive(1'b1, 4'd10, K2, D2);
            if (k == 2) inValid = 1'b0;
        end

        // Reset lands while a sample is in flight
        drive(1'b1, 4'd1, K1, D1);
        if (LAT == 1) rst = 1'b1;
        tick();
        rst = 1'b1;
        inValid = 1'b0;
        tick();
        chk_zero("rstmid_a");
        tick();
        chk_zero("rstmid_b");
        rst = 1'b0;
        tick();
        chk_zero("rstmid_c");
        send_wait("postrst", 4'd1, K1, D1);
        chk_out("postrst", 4'd1, P1, O1, 1'b0);

        // Illegal round numbers flag an error; a legal one clears it
        send_wait("ill0", 4'd0, K1, D1);
        chk("ill0_err", 128'(rndErr), 128'(1));
        chk("ill0_rnd", 128'(outRnd), 128'(0));
        send_wait("ill11", 4'd11, K1, D1);
        chk("ill11_err", 128'(rndErr), 128'(1));
        chk("ill11_rnd", 128'(outRnd), 128'(11));
        send_wait("legal", 4'd10, K2, D2);
        chk_out("legal", 4'd10, P2, O2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_round.md
Name: aes_inv_round

Overview:
Pipelined single AES-128 inverse round. It is the exact inverse of the existing forward round block.
- Input: the forward round output for round r and round key rk[r].
- Output: the forward round input and rk[r-1], produced by inverse key expansion.
- Used by the unrolled decryption datapath: ten instances chained r=10 down to 1. The top level applies the final AddRoundKey with rk[0].

Parameters:
None (fixed AES-128, 128-bit state and key).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
inValid  input  1  input sample strobe
curRnd  input  [0:3]  round number r, legal 1..10
curRK  input  [0:127]  round key rk[r]; bit 0 = MSB of byte 0
rndDataIn  input  [0:127]  forward-round-r output state; byte 0 = bits 0..7, column-major
outValid  output  1  result strobe
outRnd  output  [0:3]  curRnd carried with the data
prevRK  output  [0:127]  rk[r-1]
rndDataOut  output  [0:127]  forward-round-r input state
rndErr  output  1  curRnd was outside 1..10 for this result

Behaviour:
- Reset: synchronous, active-high.
  - On a rising edge with rst=1, all pipeline registers and all outputs clear to 0, including outValid, outRnd, prevRK, rndDataOut and rndErr.
  - inValid is ignored while rst=1.
  - In-flight data is discarded and no result is emitted for it.
- Stage 1 (registered on the inValid edge):
  - s = rndDataIn XOR curRK.
  - If r != 10, s = InvMixColumns(s); for r = 10, InvMixColumns is skipped.
  - Inverse key step, with words w0..w3 of curRK:
    - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0.
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],00,00,00}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - s, the new key, r and the error flag are all registered.
- Stage 2:
  - rndDataOut = InvSubBytes(InvShiftRows(s)).
  - prevRK, outRnd and rndErr are forwarded from stage 1.
- Latency and throughput:
  - Latency is exactly 2 cycles: inValid high at edge N gives outValid high after edge N+2.
  - Full throughput, one result per cycle. There is no backpressure.
- Output hold and invalid slots:
  - Outputs hold their last values while outValid=0.
  - A cycle with inValid=0 inserts a bubble: outValid=0 two cycles later and the data registers do not update.
- InvShiftRows: row i is rotated right by i byte positions.
- S-box and inverse S-box are computed algebraically: GF(2^8) multiplicative inverse modulo 0x11B (0 maps to 0), plus the FIPS-197 affine or inverse-affine transform. No 256-entry tables.
- InvMixColumns uses the coefficients 0E,0B,0D,09 over GF(2^8), modulo 0x11B.
- Illegal round (curRnd = 0 or 11..15):
  - Rcon = 00 and InvMixColumns is applied.
  - rndErr = 1 alongside outValid. No other special action is taken.
- Back-to-back inputs with different curRnd are independent; there is no state shared across samples.

Optional Feature:
AES_INV_SINGLE_STAGE_EN
- Defined: the stage 1 and stage 2 registers merge into a single stage, giving latency 1 cycle (inValid at edge N gives outValid after edge N+1). Throughput, reset behaviour and the result values are identical.
- Undefined: the 2-stage pipeline described above.

Test Plan:
- Forward-round-1 inverse: curRnd=1, curRK=E232FCF191129188B159E4E6D679A293, rndDataIn=5847088B15B61CBA59D4E2E8CD39DFCE, inValid for 1 cycle -> 2 cycles later outValid=1, prevRK=5468617473206D79204B756E67204675, rndDataOut=001F0E543C4E08596E221B0B4774311A, outRnd=1, rndErr=0.
- Final round (FIPS-197 App. B): curRnd=10, curRK=D014F9A8C9EE2589E13F0CC8B6630CA6, rndDataIn=3925841D02DC09FBDC118597196A0B32 -> rndDataOut=EB40F21E592E38848BA113E71BC342D2, prevRK=AC7766F319FADC2128D12941575C006E.
- Back-to-back: vector 1 then vector 2 on consecutive cycles, then a bubble -> outValid high for 2 consecutive cycles with both correct results in order, then low. Outputs hold vector 2 values.
- Reset mid-flight: inValid at edge N, rst high at edge N+1 -> outValid stays 0 and all outputs stay 0. The first valid input after rst deasserts produces a correct result at +2.
- Illegal round: curRnd=0 with vector 1 data/key -> outValid=1 with rndErr=1. curRnd=11 -> rndErr=1. The following legal input -> rndErr=0.
- With AES_INV_SINGLE_STAGE_EN defined, rerun tests 1-4 -> identical values at 1-cycle latency.
